// File: rtl/mem_access_unit.sv
// Load/store controller in front of a single-port data memory with 1-cycle
// registered read latency. Handles one request at a time: word loads/stores
// go straight through, sub-word loads extract and extend a lane, and sub-word
// stores are done as read-modify-write.
module mem_access_unit #(
    parameter int ADDR = 16,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [ADDR-1:0] req_addr,
    input  logic [1:0]      req_off,
    input  logic [1:0]      req_size,
    input  logic            req_sext,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]      r_state;
    logic            r_we;
    logic [ADDR-1:0] r_addr;
    logic [1:0]      r_off;
    logic [1:0]      r_size;
    logic            r_sext;
    logic [WORD-1:0] r_wdata;
    logic            r_err;
    logic [WORD-1:0] r_merge;
    logic [WORD-1:0] r_rdata;

    logic            w_accept;
    logic            w_req_err;
    logic [4:0]      w_shift;
    logic [WORD-1:0] w_q_shifted;
    logic [WORD-1:0] w_load_val;
    logic [WORD-1:0] w_lane_mask;
    logic [WORD-1:0] w_lane_data;
    logic [WORD-1:0] w_merge_val;

    assign w_accept = req_valid && req_ready;

    // Classify the incoming request as illegal/misaligned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_req_err = 1'b0;
        case (req_size)
            SZ_BYTE: w_req_err = 1'b0;
            SZ_HALF: w_req_err = req_off[0];
            SZ_WORD: w_req_err = (req_off != 2'b00);
            default: w_req_err = 1'b1;
        endcase
    end

    // Little-endian lane offset in bits, shared by load extraction and store merge.
    assign w_shift     = {r_off, 3'b000};
    assign w_q_shifted = mem_q >> w_shift;

    // Right-align the addressed lane and extend it.
    always_comb begin
        w_load_val = mem_q;
        case (r_size)
            SZ_BYTE: w_load_val = {{24{r_sext & w_q_shifted[7]}},  w_q_shifted[7:0]};
            SZ_HALF: w_load_val = {{16{r_sext & w_q_shifted[15]}}, w_q_shifted[15:0]};
            default: w_load_val = mem_q;
        endcase
    end

    // Build the lane mask and positioned store data for the read-modify-write.
    always_comb begin
        w_lane_mask = 32'h0000_00FF << w_shift;
        w_lane_data = {24'b0, r_wdata[7:0]} << w_shift;
        if (r_size == SZ_HALF) begin
            w_lane_mask = 32'h0000_FFFF << w_shift;
            w_lane_data = {16'b0, r_wdata[15:0]} << w_shift;
        end
    end

    assign w_merge_val = (mem_q & ~w_lane_mask) | (w_lane_data & w_lane_mask);

    // Request FSM: latch on accept, then walk RD/CAP/WR as the request needs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_merge <= '0;
            r_rdata <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_off   <= req_off;
                        r_size  <= req_size;
                        r_sext  <= req_sext;
                        r_wdata <= req_wdata;
                        r_err   <= w_req_err;
                        if (w_req_err) begin
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: r_state <= S_CAP;
                S_CAP: begin
                    if (r_we) begin
                        r_merge <= w_merge_val;
                        r_state <= S_WR;
                    end else begin
                        r_rdata <= w_load_val;
                        r_state <= S_RESP;
                    end
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = r_rdata;
    assign mem_a      = r_addr;
    // Gate with rst so a reset landing mid-WR can never commit a write.
    assign mem_w      = rst && (r_state == S_WR);
    assign mem_d      = (r_size == SZ_WORD) ? r_wdata : r_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a behavioural memory, a byte-level
// reference model, a request driver that holds req_valid until accept, and a
// per-cycle compare process.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_off;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_a;
    logic        mem_w;
    logic [31:0] mem_d;
    logic [31:0] mem_q = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR(16), .WORD(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_off(req_off), .req_size(req_size),
        .req_sext(req_sext), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    // Data memory: registered read, Q not updated on write cycles.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    always @(posedge clk) begin
        if (mem_w) mem[mem_a[7:0]] <= mem_d;
        else       mem_q <= mem[mem_a[7:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [1:0]  off;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] wdata;
        bit          has_lit;
        logic [31:0] lit;
    } req_t;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rdata;
        bit          has_lit;
        logic [31:0] lit;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    req_t rq[$];
    exp_t eq[$];
    wr_t  wq[$];
    int   busy_until = -1;
    logic [31:0] last_rdata = '0;
    bit   chk_en  = 1'b0;
    bit   drv_en  = 1'b0;
    bit   gaps_en = 1'b0;

    // Reference model: operate on bytes of the addressed word.
    function automatic void model(input req_t r, output bit err, output logic [31:0] rd,
                                  output int lat, output bit wr, output logic [31:0] new_word);
        logic [7:0]  b [4];
        logic [31:0] w, tmp;
        int nb;
        w = ref_mem[r.addr[7:0]];
        for (int k = 0; k < 4; k++) begin
            tmp  = w >> (8 * k);
            b[k] = tmp[7:0];
        end
        nb  = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        err = (r.size == 2'd3) || ((int'(r.off) % nb) != 0);
        rd = '0; wr = 1'b0; new_word = w;
        if (err) begin
            lat = 1;
        end else if (!r.we) begin
            for (int k = 0; k < nb; k++) rd = rd | ({24'b0, b[int'(r.off) + k]} << (8 * k));
            if (r.sext && nb < 4 && rd[8 * nb - 1])
                for (int k = nb; k < 4; k++) rd = rd | (32'hFF << (8 * k));
            lat = 3;
        end else begin
            for (int k = 0; k < nb; k++) begin
                tmp = r.wdata >> (8 * k);
                b[int'(r.off) + k] = tmp[7:0];
            end
            new_word = {b[3], b[2], b[1], b[0]};
            ref_mem[r.addr[7:0]] = new_word;
            lat = (nb == 4) ? 2 : 4;
            wr  = 1'b1;
        end
    endfunction

    // Driver: hold req_valid on the head request until the DUT is ready.
    initial begin
        bit holding = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!drv_en || rq.size() == 0) begin
                req_valid = 1'b0;
                holding   = 1'b0;
            end else if (!holding && gaps_en && $urandom_range(3) == 0) begin
                req_valid = 1'b0;
            end else begin
                req_we    = rq[0].we;
                req_addr  = rq[0].addr;
                req_off   = rq[0].off;
                req_size  = rq[0].size;
                req_sext  = rq[0].sext;
                req_wdata = rq[0].wdata;
                req_valid = 1'b1;
                holding   = 1'b1;
                if (req_ready) begin
                    bit e, w; logic [31:0] rd, nw; int lat, a;
                    exp_t x; wr_t y;
                    a = cyc + 1;
                    model(rq[0], e, rd, lat, w, nw);
                    x.cyc = a + lat - 1; x.err = e; x.rdata = rd;
                    x.has_lit = rq[0].has_lit; x.lit = rq[0].lit;
                    eq.push_back(x);
                    if (w) begin
                        y.cyc = a + lat - 2; y.addr = rq[0].addr; y.data = nw;
                        wq.push_back(y);
                    end
                    busy_until = a + lat - 1;
                    rq.pop_front();
                    holding = 1'b0;
                end
            end
        end
    end

    // Compare process: handshake, response and memory pins every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, (cyc > busy_until)});
            if (eq.size() != 0 && eq[0].cyc == cyc) begin
                check("resp_valid", {31'b0, resp_valid}, 32'd1);
                check("resp_err",   {31'b0, resp_err},   {31'b0, eq[0].err});
                check("resp_rdata", resp_rdata, eq[0].rdata);
                if (eq[0].has_lit) check("resp_rdata_lit", resp_rdata, eq[0].lit);
                last_rdata = eq[0].rdata;
                void'(eq.pop_front());
            end else begin
                check("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
                check("resp_err_idle",   {31'b0, resp_err},   32'd0);
                check("resp_rdata_hold", resp_rdata, last_rdata);
            end
            if (wq.size() != 0 && wq[0].cyc == cyc) begin
                check("mem_w", {31'b0, mem_w}, 32'd1);
                check("mem_a", {16'b0, mem_a}, {16'b0, wq[0].addr});
                check("mem_d", mem_d, wq[0].data);
                void'(wq.pop_front());
            end else begin
                check("mem_w_idle", {31'b0, mem_w}, 32'd0);
            end
        end
    end

    task automatic push(input bit we, input logic [15:0] addr, input logic [1:0] off,
                        input logic [1:0] size, input bit sext, input logic [31:0] wdata,
                        input bit has_lit, input logic [31:0] lit);
        req_t r;
        r.we = we; r.addr = addr; r.off = off; r.size = size; r.sext = sext;
        r.wdata = wdata; r.has_lit = has_lit; r.lit = lit;
        rq.push_back(r);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || eq.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", {31'b0, (rq.size() == 0 && eq.size() == 0)}, 32'd1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_off = '0;
        req_size = '0; req_sext = 1'b0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);

        // Reset landing in the WR cycle of a word store must block the write.
        req_we = 1'b1; req_addr = 16'd5; req_off = 2'b00; req_size = 2'b10;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_mem_w", {31'b0, mem_w}, 32'd1);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_mem_w", {31'b0, mem_w}, 32'd0);
        @(posedge clk); #1;
        check("rst_mem_unchanged", mem[5], ref_mem[5]);
        check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready},  32'd1);
        @(negedge clk); rst = 1'b1; #1;
        last_rdata = '0;
        chk_en = 1'b1;
        drv_en = 1'b1;

        // Directed sequence, queued all at once so req_valid stays held.
        push(1, 16'd3, 2'd0, 2'd2, 0, 32'h8899AABB, 1, 32'h0);
        push(0, 16'd3, 2'd0, 2'd2, 0, 32'h0,        1, 32'h8899AABB);
        push(0, 16'd3, 2'd2, 2'd0, 1, 32'h0,        1, 32'hFFFFFF99);
        push(0, 16'd3, 2'd2, 2'd0, 0, 32'h0,        1, 32'h00000099);
        push(0, 16'd3, 2'd2, 2'd1, 1, 32'h0,        1, 32'hFFFF8899);
        push(0, 16'd3, 2'd0, 2'd1, 0, 32'h0,        1, 32'h0000AABB);
        push(1, 16'd3, 2'd1, 2'd0, 0, 32'h12,       1, 32'h0);
        push(0, 16'd3, 2'd0, 2'd2, 0, 32'h0,        1, 32'h889912BB);
        push(1, 16'd3, 2'd2, 2'd1, 0, 32'h3456,     1, 32'h0);
        push(0, 16'd3, 2'd0, 2'd2, 1, 32'h0,        1, 32'h345612BB);
        push(0, 16'd3, 2'd1, 2'd1, 0, 32'h0,        1, 32'h0);
        push(1, 16'd3, 2'd2, 2'd2, 0, 32'h11111111, 1, 32'h0);
        push(1, 16'd3, 2'd0, 2'd3, 0, 32'h22222222, 1, 32'h0);
        push(0, 16'd7, 2'd0, 2'd2, 0, 32'h0,        0, 32'h0);
        push(1, 16'd7, 2'd0, 2'd2, 0, 32'hCAFEF00D, 0, 32'h0);
        push(0, 16'd7, 2'd0, 2'd2, 0, 32'h0,        1, 32'hCAFEF00D);
        drain();
        check("mem3_final_lit", mem[3], 32'h345612BB);

        // Randomized traffic over a small address window to force reuse.
        gaps_en = 1'b1;
        for (int i = 0; i < 300; i++)
            push(1'($urandom_range(1)), 16'($urandom_range(15)), 2'($urandom_range(3)),
                 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom, 0, 32'h0);
        drain();

        for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);
        check("wr_queue_empty", wq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case the handshake never completes.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
